// File: rtl/chan_pkg.sv
// Shared definitions for the channelizer packetizer.
//  - default sample / bin / length widths
//  - packet FSM state enum
//  - 2-bit beat tag carried through the output skid buffer
package chan_pkg;

  localparam int CHAN_DATA_W = 32;  // 16b I / 16b Q
  localparam int CHAN_BIN_W  = 11;  // up to 2048-point FFT
  localparam int CHAN_LEN_W  = 16;

  typedef logic [CHAN_DATA_W-1:0] chan_sample_t;

  typedef enum logic [0:0] {
    ST_START = 1'b0,
    ST_MID   = 1'b1
  } pkt_st_t;

  // Beat tag: EOB can only occur on a frame-closing beat, so the four
  // legal combinations of {tlast, frame end, eob} fit in two bits.
  //   tlast = |tag, eob = &tag, frame end = tag[1]
  localparam logic [1:0] TAG_MID     = 2'b00;
  localparam logic [1:0] TAG_PKT     = 2'b01;
  localparam logic [1:0] TAG_FRM     = 2'b10;
  localparam logic [1:0] TAG_FRM_EOB = 2'b11;

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry AXI4-Stream skid buffer used as the output register stage.
//  clk, rst_n        clock, async active-low reset
//  i_valid/i_data    upstream beat;  o_ready = registered "not full"
//  o_valid/o_data    downstream beat; i_ready = downstream ready
// r_d0 is always the head, so o_data holds while stalled. o_ready has no
// combinational path from i_ready; the second entry absorbs the one beat
// that can arrive in the cycle the stall is first seen.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic         r_rdy;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign w_push    = i_valid & r_rdy;
  assign w_pop     = (r_cnt != 2'd0) & i_ready;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_rdy <= 1'b0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      if (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)) begin
        if (w_push) r_d0 <= i_data;
      end else if (r_cnt == 2'd1) begin
        if (w_push) r_d1 <= i_data;
      end else if (w_pop) begin
        r_d0 <= r_d1;  // full: push impossible, promote second entry
      end
    end
  end

  assign o_ready = r_rdy;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_d0;

endmodule

// File: rtl/chan_bin_packetizer.sv
// Cuts the channelizer's bin-ordered sample stream into payload packets.
//  clk, reset_n        clock, async active-low reset
//  pkt_len             samples per packet (0 -> 1), sampled at packet start
//  eob_req             pulse: tag EOB on the next frame-closing packet
//  s_axis_*            input samples, tuser = bin, tlast = end of FFT frame
//  m_axis_*            output packets, tuser = first bin of packet,
//                      tlast = end of packet, eob valid with tlast
//  frame_cnt           frames fully emitted on the output, mod 2^16
// Packet state is evaluated on the input side; each beat carries its
// packet's first bin and a 2-bit tag through a 2-entry skid buffer.
module chan_bin_packetizer
  import chan_pkg::*;
#(
  parameter int DATA_W = CHAN_DATA_W,
  parameter int BIN_W  = CHAN_BIN_W,
  parameter int LEN_W  = CHAN_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              eob_req,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [BIN_W-1:0]  s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [BIN_W-1:0]  m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_eob,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [15:0]       frame_cnt
);

  localparam int SKID_W = DATA_W + BIN_W + 2;

  pkt_st_t            r_state;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len_q;
  logic [BIN_W-1:0]   r_first_bin;
  logic               r_eob_pend;
  logic [15:0]        r_frame_cnt;

  logic               w_s_fire;
  logic               w_start;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_cnt;
  logic [BIN_W-1:0]   w_bin;
  logic               w_close;
  logic               w_eob;
  logic [1:0]         w_tag;
  logic [SKID_W-1:0]  w_skid_in;
  logic [SKID_W-1:0]  w_skid_out;
  logic [1:0]         w_out_tag;

  assign w_s_fire = s_axis_tvalid & s_axis_tready;

  // At packet start the live pkt_len / tuser are used so a 1-beat packet
  // never needs to leave the start state.
  always_comb begin
    w_start = (r_state == ST_START);
    w_len   = r_len_q;
    w_cnt   = r_cnt;
    w_bin   = r_first_bin;
    if (w_start) begin
      w_len = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
      w_cnt = '0;
      w_bin = s_axis_tuser;
    end
    w_close = (w_cnt == w_len - LEN_W'(1)) | s_axis_tlast;
    // same-cycle request counts for the closing beat
    w_eob   = s_axis_tlast & (r_eob_pend | eob_req);
    w_tag   = TAG_MID;
    if (w_close) begin
      if (!s_axis_tlast) w_tag = TAG_PKT;
      else if (w_eob)    w_tag = TAG_FRM_EOB;
      else               w_tag = TAG_FRM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_START;
      r_cnt       <= '0;
      r_len_q     <= LEN_W'(1);
      r_first_bin <= '0;
      r_eob_pend  <= 1'b0;
    end else begin
      if (w_s_fire) begin
        if (w_close) begin
          r_state <= ST_START;
          r_cnt   <= '0;
        end else begin
          r_state     <= ST_MID;
          r_cnt       <= w_cnt + LEN_W'(1);
          r_len_q     <= w_len;
          r_first_bin <= w_bin;
        end
      end
      // frame close consumes the pending tag (and any coincident request)
      if (w_s_fire && s_axis_tlast) r_eob_pend <= 1'b0;
      else if (eob_req)             r_eob_pend <= 1'b1;
    end
  end

  assign w_skid_in = {s_axis_tdata, w_bin, w_tag};

  axis_skid_buf #(.W(SKID_W)) u_skid (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (s_axis_tvalid),
    .i_data  (w_skid_in),
    .o_ready (s_axis_tready),
    .o_valid (m_axis_tvalid),
    .o_data  (w_skid_out),
    .i_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tuser, w_out_tag} = w_skid_out;
  assign m_axis_tlast = |w_out_tag;
  assign m_axis_eob   = &w_out_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_frame_cnt <= 16'd0;
    else if (m_axis_tvalid && m_axis_tready && w_out_tag[1])
      r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_chan_bin_packetizer.sv
module tb_chan_bin_packetizer;

  logic        clk;
  logic        reset_n;
  logic [15:0] pkt_len;
  logic        eob_req;
  logic [31:0] s_axis_tdata;
  logic [10:0] s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [10:0] m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_eob;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] frame_cnt;

  chan_bin_packetizer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pkt_len       (pkt_len),
    .eob_req       (eob_req),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_eob    (m_axis_eob),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [10:0] u;
    logic        l;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_exp = 0;
  bit   rnd_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // downstream ready driver
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // monitor: hold-while-stalled check and scoreboard pop
  initial begin
    logic prev_stall;
    exp_t prev, e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          checks++;
          if (!(m_axis_tvalid && m_axis_tdata == prev.d && m_axis_tuser == prev.u &&
                m_axis_tlast == prev.l && m_axis_eob == prev.e)) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b d=%0h u=%0d l=%0b e=%0b held d=%0h u=%0d l=%0b e=%0b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_eob,
                     prev.d, prev.u, prev.l, prev.e);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got d=%0h u=%0d l=%0b with empty scoreboard",
                     m_axis_tdata, m_axis_tuser, m_axis_tlast);
          end else begin
            e = q.pop_front();
            if (m_axis_tdata !== e.d || m_axis_tuser !== e.u || m_axis_tlast !== e.l ||
                m_axis_eob !== e.e) begin
              errors++;
              $display("FAIL beat: got d=%0h u=%0d l=%0b e=%0b expected d=%0h u=%0d l=%0b e=%0b",
                       m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_eob, e.d, e.u, e.l, e.e);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev.d = m_axis_tdata;
        prev.u = m_axis_tuser;
        prev.l = m_axis_tlast;
        prev.e = m_axis_eob;
      end
    end
  end

  // Present one beat until accepted; eob_req (if asked) is a one-cycle pulse.
  task automatic send_beat(input logic [31:0] d, input int bin, input bit last,
                           input bit pulse, output int c);
    bit acc;
    s_axis_tdata  = d;
    s_axis_tuser  = 11'(bin);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    eob_req       = pulse;
    c = 0;
    forever begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      eob_req = 1'b0;
      c++;
      if (acc) break;
      if (c > 500) begin
        errors++;
        $display("FAIL input_timeout: got no s_axis_tready in %0d cycles, expected acceptance", c);
        break;
      end
    end
  endtask

  // Reference model: beat i of an n-beat frame with effective length L sits at
  // offset i%L in a packet that starts at bin i-i%L; it ends the packet at
  // offset L-1 or at the frame's last beat; EOB only on the frame's last beat.
  task automatic send_frame(input int n, input int len, input int pulse_at,
                            input bit lat_chk, output int cyc);
    logic [31:0] data[];
    exp_t e;
    int L, c;
    L = (len == 0) ? 1 : len;
    data = new[n];
    for (int i = 0; i < n; i++) begin
      int pos;
      data[i] = $urandom;
      pos = i % L;
      e.d = data[i];
      e.u = 11'(i - pos);
      e.l = (pos == L - 1) || (i == n - 1);
      e.e = (i == n - 1) && (pulse_at >= 0);
      q.push_back(e);
    end
    frames_exp++;
    pkt_len = 16'(len);
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd_ready && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(data[i], i, i == n - 1, i == pulse_at, c);
      cyc += c;
      if (lat_chk && i == 0) begin
        chk("latency_valid", m_axis_tvalid, 1);
        chk("latency_tuser", m_axis_tuser, 0);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() > 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_drained"}, q.size(), 0);
    @(posedge clk);
    #1;
    chk({name, "_frame_cnt"}, frame_cnt, 64'(16'(frames_exp)));
  endtask

  initial begin
    int cyc, n, len, pulse;
    exp_t e;
    logic [31:0] d6[6];

    // 1: reset with valid input held high
    reset_n = 1'b0;
    pkt_len = 16'd4;
    eob_req = 1'b0;
    s_axis_tdata = 32'hdead_beef;
    s_axis_tuser = 11'd5;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", s_axis_tready, 1);

    // 2: pkt_len=4 over a 10-beat frame, full throughput
    send_frame(10, 4, -1, 1'b1, cyc);
    chk("tput_cycles", cyc, 10);
    drain("t2");

    // 3: length 0 and 1 -> single-beat packets
    send_frame(3, 0, -1, 1'b0, cyc);
    send_frame(3, 1, -1, 1'b0, cyc);
    drain("t3");

    // 4: EOB mid-frame, none, and coincident with closing beat
    send_frame(10, 4, 5, 1'b0, cyc);
    send_frame(10, 4, -1, 1'b0, cyc);
    send_frame(10, 4, 9, 1'b0, cyc);
    drain("t4");

    // 5: random backpressure, random lengths and EOB
    rnd_ready = 1;
    repeat (1000) begin
      n = $urandom_range(1, 12);
      len = $urandom_range(0, 5);
      pulse = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      send_frame(n, len, pulse, 1'b0, cyc);
    end
    drain("t5");
    rnd_ready = 0;
    @(posedge clk);
    #1;

    // 6: pkt_len 4->2 after bin 0, reset while bin 6 is presented
    for (int i = 0; i < 6; i++) begin
      d6[i] = $urandom;
      e.d = d6[i];
      e.u = (i < 4) ? 11'd0 : 11'd4;
      e.l = (i == 3) || (i == 5);
      e.e = 1'b0;
      q.push_back(e);
    end
    pkt_len = 16'd4;
    for (int i = 0; i < 6; i++) begin
      send_beat(d6[i], i, 1'b0, 1'b0, cyc);
      pkt_len = 16'd2;
    end
    s_axis_tdata = $urandom;
    s_axis_tuser = 11'd6;
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    chk("t6_rst_valid", m_axis_tvalid, 0);
    chk("t6_rst_tlast", m_axis_tlast, 0);
    chk("t6_rst_frame_cnt", frame_cnt, 0);
    chk("t6_rst_tdata", m_axis_tdata, 0);
    chk("t6_pre_reset_beats", q.size(), 0);
    frames_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4, 2, -1, 1'b0, cyc);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
